// File: rtl/oport_credit_arbiter.sv
// Output-port switch scheduler: weighted round-robin over input ports, per-VC downstream
// credit tracking, and packet lock. Define OPORT_ARB_CHK_EN to build the sticky err checks.
module oport_credit_arbiter #(
    parameter int V       = 4,
    parameter int P       = 5,
    parameter int B       = 4,
    parameter int WEIGHTW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P-1:0]         req,
    input  logic [P*V-1:0]       req_ovc,
    input  logic [P-1:0]         req_tail,
    input  logic [P*WEIGHTW-1:0] weight_all,
    input  logic [V-1:0]         credit_in,
    output logic [P-1:0]         grant,
    output logic [V-1:0]         grant_ovc,
    output logic                 flit_we,
    output logic [V-1:0]         ovc_full,
    output logic                 locked,
    output logic                 err
);
    localparam int CW = $clog2(B + 1);
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(B);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q;
    logic [PW-1:0]      owner_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [WEIGHTW-1:0] wcnt_q;
    logic [WEIGHTW-1:0] wcnt_d;
    logic [CW-1:0]      cnt_q [V];
    logic [V-1:0]       vc_ok_s;
    logic [P-1:0]       elig_s;
    logic [PW-1:0]      win_s;
    logic [PW-1:0]      nxt_s;
    logic               found_s;
    logic               tail_s;

    function automatic logic [WEIGHTW-1:0] load_weight(input logic [P*WEIGHTW-1:0] w_all,
                                                       input logic [PW-1:0] idx);
        logic [WEIGHTW-1:0] w;
        w = w_all[idx*WEIGHTW +: WEIGHTW];
        return (w == {WEIGHTW{1'b0}}) ? WEIGHTW'(1) : w;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(P - 1)) ? {PW{1'b0}} : idx + PW'(1);
    endfunction

    // Eligibility: a requester needs a credit on its target VC
    always_comb begin
        for (int v = 0; v < V; v++) begin
            vc_ok_s[v] = (cnt_q[v] != {CW{1'b0}});
        end
        for (int i = 0; i < P; i++) begin
            elig_s[i] = req[i] & (|(req_ovc[i*V +: V] & vc_ok_s));
        end
    end

    // Winner selection: owner only while locked, else rotating scan from ptr
    always_comb begin
        int idx;
        logic hit;
        win_s   = ptr_q;
        found_s = 1'b0;
        idx     = 0;
        hit     = 1'b0;
        if (reset) begin
            found_s = 1'b0;
        end else if (state_q == LOCKED) begin
            win_s   = owner_q;
            found_s = elig_s[owner_q];
        end else begin
            for (int k = 0; k < P; k++) begin
                idx     = int'(ptr_q) + k;
                idx     = (idx >= P) ? idx - P : idx;
                hit     = ~found_s & elig_s[idx];
                win_s   = hit ? PW'(idx) : win_s;
                found_s = found_s | elig_s[idx];
            end
        end
    end

    // Grant decode and packet-end pointer/weight update
    always_comb begin
        for (int i = 0; i < P; i++) begin
            grant[i] = found_s & (win_s == PW'(i));
        end
        grant_ovc = found_s ? req_ovc[win_s*V +: V] : {V{1'b0}};
        tail_s    = found_s & req_tail[win_s];
        flit_we   = |grant;
        nxt_s     = next_idx(win_s);
        if ((wcnt_q <= WEIGHTW'(1)) || !req[win_s]) begin
            ptr_d  = nxt_s;
            wcnt_d = load_weight(weight_all, nxt_s);
        end else begin
            ptr_d  = win_s;
            wcnt_d = wcnt_q - WEIGHTW'(1);
        end
    end

    assign ovc_full = ~vc_ok_s;
    assign locked   = (state_q == LOCKED);

    // Packet lock FSM with round-robin pointer and remaining weight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= {PW{1'b0}};
            ptr_q   <= {PW{1'b0}};
            wcnt_q  <= load_weight(weight_all, {PW{1'b0}});
        end else begin
            case (state_q)
                IDLE: begin
                    if (flit_we && tail_s) begin
                        ptr_q  <= ptr_d;
                        wcnt_q <= wcnt_d;
                    end else if (flit_we) begin
                        owner_q <= win_s;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (flit_we && tail_s) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                        wcnt_q  <= wcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Credit counters; an over-return saturates at the buffer depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                cnt_q[v] <= CNT_MAX;
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !(flit_we && grant_ovc[v])) begin
                    if (cnt_q[v] != CNT_MAX) begin
                        cnt_q[v] <= cnt_q[v] + CW'(1);
                    end
                end else if (!credit_in[v] && flit_we && grant_ovc[v]) begin
                    cnt_q[v] <= cnt_q[v] - CW'(1);
                end
            end
        end
    end

`ifdef OPORT_ARB_CHK_EN
    logic [V-1:0] lock_vc_q;
    logic [V-1:0] ovf_s;
    logic         vc_mis_s;
    logic         err_q;

    always_comb begin
        for (int v = 0; v < V; v++) begin
            ovf_s[v] = credit_in[v] & (cnt_q[v] == CNT_MAX) & ~(flit_we & grant_ovc[v]);
        end
        vc_mis_s = (state_q == LOCKED) & req[owner_q] & (req_ovc[owner_q*V +: V] != lock_vc_q);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vc_q <= {V{1'b0}};
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && flit_we && !tail_s) begin
                lock_vc_q <= grant_ovc;
            end
            if (|ovf_s) begin
                err_q <= 1'b1;
                $display("%m: credit overflow on vc mask %b at %0t", ovf_s, $time);
            end
            if (vc_mis_s) begin
                err_q <= 1'b1;
                $display("%m: locked requester changed req_ovc at %0t", $time);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oport_credit_arbiter.sv
// Directed self-checking bench for oport_credit_arbiter (V=4, P=5, B=4, WEIGHTW=4).
module tb_oport_credit_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  req = 5'b0;
    logic [19:0] req_ovc = 20'b0;
    logic [4:0]  req_tail = 5'b0;
    logic [19:0] weight_all = 20'b0;
    logic [3:0]  credit_in = 4'b0;
    logic [4:0]  grant;
    logic [3:0]  grant_ovc;
    logic        flit_we;
    logic [3:0]  ovc_full;
    logic        locked;
    logic        err;
    int          total = 0;
    int          bad = 0;

    oport_credit_arbiter #(.V(4), .P(5), .B(4), .WEIGHTW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_ovc(req_ovc), .req_tail(req_tail),
        .weight_all(weight_all), .credit_in(credit_in), .grant(grant), .grant_ovc(grant_ovc),
        .flit_we(flit_we), .ovc_full(ovc_full), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = 5'b0;
        req_tail = 5'b0;
        credit_in = 4'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        if (grant !== 5'b00000) begin bad++; $display("FAIL rst_grant got=%b exp=%b", grant, 5'b00000); end total++;
        if (grant_ovc !== 4'b0000) begin bad++; $display("FAIL rst_gvc got=%b exp=%b", grant_ovc, 4'b0000); end total++;
        if (flit_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", flit_we); end total++;
        if (ovc_full !== 4'b0000) begin bad++; $display("FAIL rst_full got=%b exp=%b", ovc_full, 4'b0000); end total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end total++;
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end total++;
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [4];
        exp_g[0] = 5'b00010; exp_g[1] = 5'b00100; exp_g[2] = 5'b00010; exp_g[3] = 5'b00100;
        req = 5'b00110; req_tail = 5'b11111; req_ovc = {5{4'b0001}};
        for (int c = 0; c < 4; c++) begin
            #1;
            if (grant !== exp_g[c]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", c, grant, exp_g[c]); end total++;
            if (ovc_full !== 4'b0000) begin bad++; $display("FAIL rr_notfull%0d got=%b exp=%b", c, ovc_full, 4'b0000); end total++;
            tick();
        end
        if (ovc_full !== 4'b0001) begin bad++; $display("FAIL rr_full got=%b exp=%b", ovc_full, 4'b0001); end total++;
        if (grant !== 5'b00000) begin bad++; $display("FAIL rr_block got=%b exp=%b", grant, 5'b00000); end total++;
        apply_reset();
    endtask

    task automatic test_locked_packet();
        req_ovc = {4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        req = 5'b01010; req_tail = 5'b01000;
        #1;
        if (grant !== 5'b00010 || locked !== 1'b0) begin bad++; $display("FAIL lk_head got=%b/%b exp=00010/0", grant, locked); end total++;
        tick();
        if (grant !== 5'b00010 || locked !== 1'b1) begin bad++; $display("FAIL lk_body got=%b/%b exp=00010/1", grant, locked); end total++;
        if (grant_ovc !== 4'b0100) begin bad++; $display("FAIL lk_gvc got=%b exp=%b", grant_ovc, 4'b0100); end total++;
        tick();
        req = 5'b01000;
        #1;
        if (grant !== 5'b00000 || locked !== 1'b1) begin bad++; $display("FAIL lk_bubble got=%b/%b exp=00000/1", grant, locked); end total++;
        tick();
        req = 5'b01010; req_tail = 5'b01010;
        #1;
        if (grant !== 5'b00010 || locked !== 1'b1) begin bad++; $display("FAIL lk_tail got=%b/%b exp=00010/1", grant, locked); end total++;
        tick();
        req = 5'b01000;
        #1;
        if (grant !== 5'b01000 || locked !== 1'b0) begin bad++; $display("FAIL lk_next got=%b/%b exp=01000/0", grant, locked); end total++;
        apply_reset();
    endtask

    task automatic test_credit_block();
        req = 5'b00001; req_tail = 5'b11111; req_ovc = {16'b0, 4'b0010};
        for (int c = 0; c < 4; c++) begin
            #1;
            if (grant !== 5'b00001 || ovc_full !== 4'b0000) begin bad++; $display("FAIL cb_send%0d got=%b/%b exp=00001/0000", c, grant, ovc_full); end total++;
            tick();
        end
        if (ovc_full !== 4'b0010) begin bad++; $display("FAIL cb_full got=%b exp=%b", ovc_full, 4'b0010); end total++;
        if (grant !== 5'b00000) begin bad++; $display("FAIL cb_block got=%b exp=%b", grant, 5'b00000); end total++;
        credit_in = 4'b0010;
        #1;
        if (grant !== 5'b00000) begin bad++; $display("FAIL cb_cr_same got=%b exp=%b", grant, 5'b00000); end total++;
        tick();
        credit_in = 4'b0000;
        #1;
        if (grant !== 5'b00001 || ovc_full !== 4'b0000) begin bad++; $display("FAIL cb_resume got=%b/%b exp=00001/0000", grant, ovc_full); end total++;
        apply_reset();
    endtask

    task automatic test_weights();
        logic [4:0] exp_g [8];
        // wcnt is reloaded from the slot the pointer lands on, so input 3 (idle) carries weight 3
        weight_all = {4'd0, 4'd3, 4'd1, 4'd0, 4'd3};
        apply_reset();
        exp_g[0] = 5'b00001; exp_g[1] = 5'b00001; exp_g[2] = 5'b00001; exp_g[3] = 5'b00100;
        exp_g[4] = 5'b00001; exp_g[5] = 5'b00001; exp_g[6] = 5'b00001; exp_g[7] = 5'b00100;
        req = 5'b00101; req_tail = 5'b11111; req_ovc = {5{4'b1000}}; credit_in = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (grant !== exp_g[c]) begin bad++; $display("FAIL wt_grant%0d got=%b exp=%b", c, grant, exp_g[c]); end total++;
            tick();
        end
        weight_all = 20'b0;
        apply_reset();
    endtask

    task automatic test_same_cycle_and_reset();
        req = 5'b00001; req_tail = 5'b11111; req_ovc = {16'b0, 4'b0100};
        for (int c = 0; c < 5; c++) begin
            credit_in = (c == 2) ? 4'b0100 : 4'b0000;
            #1;
            if (grant !== 5'b00001 || ovc_full !== 4'b0000) begin bad++; $display("FAIL sc_send%0d got=%b/%b exp=00001/0000", c, grant, ovc_full); end total++;
            tick();
        end
        credit_in = 4'b0000;
        if (ovc_full !== 4'b0100 || grant !== 5'b00000) begin bad++; $display("FAIL sc_full got=%b/%b exp=0100/00000", ovc_full, grant); end total++;
        req = 5'b00010; req_tail = 5'b00000; req_ovc = {12'b0, 4'b0001, 4'b0100};
        #1;
        if (grant !== 5'b00010) begin bad++; $display("FAIL rl_head got=%b exp=%b", grant, 5'b00010); end total++;
        tick();
        if (locked !== 1'b1) begin bad++; $display("FAIL rl_locked got=%b exp=1", locked); end total++;
        reset = 1'b1; req = 5'b00000;
        #1;
        if (locked !== 1'b0 || grant !== 5'b00000) begin bad++; $display("FAIL rl_async got=%b/%b exp=0/00000", locked, grant); end total++;
        tick();
        reset = 1'b0;
        #1;
        if (locked !== 1'b0 || ovc_full !== 4'b0000 || grant !== 5'b00000) begin bad++; $display("FAIL rl_after got=%b/%b/%b exp=0/0000/00000", locked, ovc_full, grant); end total++;
    endtask

    task automatic test_overflow();
        logic exp_err;
`ifdef OPORT_ARB_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apply_reset();
        credit_in = 4'b0001;
        tick();
        credit_in = 4'b0000;
        if (err !== exp_err) begin bad++; $display("FAIL ov_err got=%b exp=%b", err, exp_err); end total++;
        tick();
        tick();
        if (err !== exp_err) begin bad++; $display("FAIL ov_sticky got=%b exp=%b", err, exp_err); end total++;
        req = 5'b00001; req_tail = 5'b11111; req_ovc = {16'b0, 4'b0001};
        for (int c = 0; c < 4; c++) begin
            #1;
            if (grant !== 5'b00001 || ovc_full !== 4'b0000) begin bad++; $display("FAIL ov_sat%0d got=%b/%b exp=00001/0000", c, grant, ovc_full); end total++;
            tick();
        end
        if (ovc_full !== 4'b0001 || grant !== 5'b00000) begin bad++; $display("FAIL ov_full got=%b/%b exp=0001/00000", ovc_full, grant); end total++;
        apply_reset();
        if (err !== 1'b0) begin bad++; $display("FAIL ov_clear got=%b exp=0", err); end total++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_credit_block();
        test_weights();
        test_same_cycle_and_reset();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
